// File: rtl/axi_s_abs_pkg.sv
// Shared definitions for the AXI-Stream absolute-value accumulator:
// default widths and the output buffer state encoding.
package axi_s_abs_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ACC_W_DEF  = 48;
  localparam int CNT_W_DEF  = 16;
  localparam int TID_W_DEF  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } obuf_state_e;

endpackage

// File: rtl/axi_s_abs_accum_chan.sv
// One accumulator channel: saturating packet sum, saturating beat count and
// sticky overflow flag for a single stream ID. The sum/count/flag that would
// result from accepting the current beat are presented combinationally, so
// the top can capture them on the last beat while this channel clears.
// Optional peak tracking is enabled with ABS_ACCUM_PEAK_EN.
module abs_accum_chan
  import axi_s_abs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              beat_i,
  input  logic              last_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              ovf_o
`ifdef ABS_ACCUM_PEAK_EN
  ,
  output logic [DATA_W-1:0] peak_o
`endif
);

  logic [ACC_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic [ACC_W:0]   sum_wide;
  logic             sum_sat;
  logic             cnt_sat;
`ifdef ABS_ACCUM_PEAK_EN
  logic [DATA_W-1:0] peak_q;
`endif

  // Candidate results of adding this beat, clamped at the all-ones value.
  // NOTE: every output of a combinational block is assigned on every path;
  // a missing assignment would infer a latch.
  always_comb begin
    sum_wide = {1'b0, acc_q} + (ACC_W + 1)'(data_i);
    sum_sat  = sum_wide[ACC_W];
    cnt_sat  = &cnt_q;
    sum_o    = sum_sat ? '1 : sum_wide[ACC_W-1:0];
    cnt_o    = cnt_sat ? cnt_q : cnt_q + CNT_W'(1);
    ovf_o    = ovf_q | sum_sat | cnt_sat;
`ifdef ABS_ACCUM_PEAK_EN
    peak_o   = (data_i > peak_q) ? data_i : peak_q;
`endif
  end

  // Accumulate non-last beats; a last beat hands off the result and clears.
  // NOTE: the per-ID state is reset so a packet cut short by reset leaves no
  // partial sum behind; state registers use non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
`ifdef ABS_ACCUM_PEAK_EN
      peak_q <= '0;
`endif
    end else if (beat_i) begin
      if (last_i) begin
        acc_q  <= '0;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
`ifdef ABS_ACCUM_PEAK_EN
        peak_q <= '0;
`endif
      end else begin
        acc_q  <= sum_o;
        cnt_q  <= cnt_o;
        ovf_q  <= ovf_o;
`ifdef ABS_ACCUM_PEAK_EN
        peak_q <= peak_o;
`endif
      end
    end
  end

endmodule

// File: rtl/axi_s_abs_accum.sv
// AXI-Stream per-ID accumulator of CORDIC magnitudes. Beats are summed per
// stream ID; each packet's sum, beat count and overflow flag are emitted in
// a one-entry output buffer one cycle after its last beat.
// Define ABS_ACCUM_PEAK_EN to add the per-packet peak output sm_tpeak_o.
module axi_s_abs_accum
  import axi_s_abs_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TID_W  = TID_W_DEF
) (
  input  logic              ss_clk_i,
  input  logic              ss_aresetn_i,
  input  logic              ss_tvalid_i,
  input  logic              ss_tlast_i,
  input  logic [TID_W-1:0]  ss_tid_i,
  input  logic [DATA_W-1:0] ss_tdata_i,
  output logic              ss_tready_o,
  output logic              sm_tvalid_o,
  input  logic              sm_tready_i,
  output logic [TID_W-1:0]  sm_tid_o,
  output logic [ACC_W-1:0]  sm_tsum_o,
  output logic [CNT_W-1:0]  sm_tcnt_o,
  output logic              sm_tovf_o
`ifdef ABS_ACCUM_PEAK_EN
  ,
  output logic [DATA_W-1:0] sm_tpeak_o
`endif
);

  localparam int NUM_CH = 1 << TID_W;

  obuf_state_e      state_q;
  logic [TID_W-1:0] tid_q;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             accept;
  logic             accept_last;

  logic [ACC_W-1:0] chan_sum [NUM_CH];
  logic [CNT_W-1:0] chan_cnt [NUM_CH];
  logic             chan_ovf [NUM_CH];
`ifdef ABS_ACCUM_PEAK_EN
  logic [DATA_W-1:0] chan_peak [NUM_CH];
  logic [DATA_W-1:0] peak_q;
`endif

  // The buffer can take a new result when empty or when it drains this cycle.
  assign ss_tready_o = (state_q == EMPTY) | sm_tready_i;
  assign accept      = ss_tvalid_i & ss_tready_o;
  assign accept_last = accept & ss_tlast_i;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    abs_accum_chan #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk_i   (ss_clk_i),
      .rst_n_i (ss_aresetn_i),
      .beat_i  (accept && (ss_tid_i == TID_W'(k))),
      .last_i  (ss_tlast_i),
      .data_i  (ss_tdata_i),
      .sum_o   (chan_sum[k]),
      .cnt_o   (chan_cnt[k]),
      .ovf_o   (chan_ovf[k])
`ifdef ABS_ACCUM_PEAK_EN
      ,
      .peak_o  (chan_peak[k])
`endif
    );
  end

  // Output buffer FSM: load on an accepted last beat (also while draining),
  // otherwise empty once the downstream takes the held result.
  always_ff @(posedge ss_clk_i or negedge ss_aresetn_i) begin
    if (!ss_aresetn_i) begin
      state_q <= EMPTY;
      tid_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
`ifdef ABS_ACCUM_PEAK_EN
      peak_q  <= '0;
`endif
    end else begin
      case (state_q)
        EMPTY: if (accept_last) state_q <= FULL;
        FULL:  if (!accept_last && sm_tready_i) state_q <= EMPTY;
      endcase
      if (accept_last) begin
        tid_q  <= ss_tid_i;
        sum_q  <= chan_sum[ss_tid_i];
        cnt_q  <= chan_cnt[ss_tid_i];
        ovf_q  <= chan_ovf[ss_tid_i];
`ifdef ABS_ACCUM_PEAK_EN
        peak_q <= chan_peak[ss_tid_i];
`endif
      end
    end
  end

  assign sm_tvalid_o = (state_q == FULL);
  assign sm_tid_o    = tid_q;
  assign sm_tsum_o   = sum_q;
  assign sm_tcnt_o   = cnt_q;
  assign sm_tovf_o   = ovf_q;
`ifdef ABS_ACCUM_PEAK_EN
  assign sm_tpeak_o  = peak_q;
`endif

endmodule

// File: doc/axi_s_abs_accum.md
AXI_S_ABS_ACCUM -- requirements
Module: axi_s_abs_accum

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the input magnitude width.
REQ-002 The block SHALL have parameter ACC_W, default 48, giving the packet sum width (ACC_W >= DATA_W).
REQ-003 The block SHALL have parameter CNT_W, default 16, giving the beat count width.
REQ-004 The block SHALL have parameter TID_W, default 2, giving the stream ID width; one accumulator channel exists per ID value.
REQ-005 The block SHALL have port ss_clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port ss_aresetn_i, input, 1 bit: asynchronous active-low reset.
REQ-007 The block SHALL have the following input-stream ports: ss_tvalid_i in 1; ss_tlast_i in 1; ss_tid_i in TID_W; ss_tdata_i in DATA_W (unsigned magnitude from the CORDIC abs stage); ss_tready_o out 1.
REQ-008 The block SHALL have the following output-stream ports: sm_tvalid_o out 1; sm_tready_i in 1; sm_tid_o out TID_W; sm_tsum_o out ACC_W; sm_tcnt_o out CNT_W; sm_tovf_o out 1 (saturation occurred in the packet).

Function
REQ-009 An input beat SHALL be accepted only on a cycle with ss_tvalid_i=1 and ss_tready_o=1.
REQ-010 ss_tready_o SHALL equal (output buffer EMPTY) OR sm_tready_i, and it SHALL be combinational from sm_tready_i only.
REQ-011 A non-last accepted beat for ID k SHALL add ss_tdata_i (zero-extended) to acc[k] and increment cnt[k].
REQ-012 A last accepted beat for ID k SHALL load the output buffer with sum=acc[k]+data, cnt=cnt[k]+1, ID=k and the accumulated ovf flag, and SHALL clear acc[k], cnt[k] and ovf[k] in the same cycle.
REQ-013 A single-beat packet (tlast on the first beat) SHALL produce sum=data and cnt=1.
REQ-014 The sum SHALL saturate at 2^ACC_W-1 and the count SHALL saturate at 2^CNT_W-1; either saturation SHALL set ovf[k], which stays set until that packet is emitted.
REQ-015 The channels SHALL be independent: interleaved IDs accumulate without interference.
REQ-016 The output buffer FSM SHALL have states EMPTY and FULL; EMPTY->FULL on an accepted last beat; FULL->EMPTY on sm_tready_i=1 with no new last beat; FULL->FULL (reload) on a simultaneous output handshake and accepted last beat.
REQ-017 The latency SHALL be 1 cycle from an accepted last beat to sm_tvalid_o=1.
REQ-018 sm_tvalid_o SHALL equal (state==FULL), and the output fields SHALL be held stable while sm_tvalid_o=1 and sm_tready_i=0.
REQ-019 With ss_tvalid_i=0 the state SHALL not change except for the output drain.
REQ-020 Full-throughput operation (one beat per cycle, continuous last beats with sm_tready_i=1) SHALL sustain without bubbles.

Reset
REQ-021 Asserting ss_aresetn_i low SHALL immediately clear all acc, cnt and ovf, set the state to EMPTY, set sm_tvalid_o=0, sm_tsum_o=0, sm_tcnt_o=0, sm_tid_o=0 and sm_tovf_o=0.
REQ-022 A reset mid-packet SHALL discard the partial sums; the first beat after deassertion SHALL start a new packet.

Configuration
REQ-023 When ABS_ACCUM_PEAK_EN is defined, the block SHALL add output port sm_tpeak_o of DATA_W bits, equal to the maximum data value of the emitted packet, tracked per ID, cleared with acc and reset to 0.
REQ-024 When ABS_ACCUM_PEAK_EN is undefined, the port and the peak registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 The shared package axi_s_abs_pkg SHALL hold the default widths and the output buffer state enum (EMPTY, FULL).
REQ-026 The per-ID saturating accumulate logic SHALL be one sub-module, abs_accum_chan, instantiated 2^TID_W times.

Verification
REQ-027 The bench SHALL cover: ID0 beats 10, 20, 30 (last on 30), sm_tready_i=1 -> one output beat with tid=0, sum=60, cnt=3, ovf=0, one cycle after the last beat.
REQ-028 The bench SHALL cover: interleaved ID1 5, ID2 7, ID1 6(last), ID2 8(last) -> outputs {tid1, sum 11, cnt 2} then {tid2, sum 15, cnt 2}.
REQ-029 The bench SHALL cover: sm_tready_i=0 with the buffer FULL and a new last beat pending -> ss_tready_o=0 and the output held stable; on sm_tready_i=1 the next result is loaded in the same cycle.
REQ-030 The bench SHALL cover: ACC_W=33, two beats of 0xFFFFFFFF plus a last beat of 0xFFFFFFFF -> sum=0x1FFFFFFFF and ovf=1.
REQ-031 The bench SHALL cover: reset asserted after 2 beats of ID3 -> sm_tvalid_o=0; then beat 4(last) on ID3 -> sum=4, cnt=1.
REQ-032 The bench SHALL cover: with ABS_ACCUM_PEAK_EN defined, beats 3, 9, 2(last) -> sm_tpeak_o=9, sum=14.
